ifu_pc_gen: RTL and testbench

- Fetch-side consumer of the EX-stage branch decision: owns the architectural PC and issues instruction fetches to IMEM over a valid/ready request plus a response channel.
- Hands fetched instructions to IDU over valid/ready.
- Applies branch/jump redirects and discards wrong-path fetches that are in flight.
- Sits between IMEM and IDU in the multi-cycle NPC core.

---
 rtl/ifu_pc_gen_pkg.sv | 18 +
 rtl/ifu_pc_gen_redirect_sel.sv | 19 +
 rtl/ifu_pc_gen.sv | 131 +++++++++++++
 tb/tb_ifu_pc_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pc_gen_pkg.sv
// rtl/ifu_pc_gen_pkg.sv - shared fetch-unit state encodings, reset PC and address helpers
package ifu_pc_gen_pkg;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_PC_STEP  = 32'd4;

    // Instruction fetches are word aligned; redirect targets drop their byte offset.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_pc_gen_redirect_sel.sv
// rtl/ifu_pc_gen_redirect_sel.sv - jump/branch target priority select and redirect pulse
module ifu_pc_gen_redirect_sel
    import ifu_pc_gen_pkg::*;
(
    input  logic        ex_fire,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output logic        redirect,
    output logic [31:0] target
);

    always_comb begin
        redirect = ex_fire & (jmp_valid | br_taken);
        target   = align_word(jmp_valid ? jmp_target : br_target);
    end

endmodule

// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - PC owner and IMEM fetch FSM feeding IDU, with redirect and wrong-path drop
module ifu_pc_gen
    import ifu_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter logic [31:0] PC_STEP  = IFU_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_fire,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        flush
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        drop_q, drop_d;

    logic        redirect;
    logic [31:0] target;

    ifu_pc_gen_redirect_sel u_redirect_sel (
        .ex_fire    (ex_fire),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .redirect   (redirect),
        .target     (target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IFU_REQ;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        drop_d       = drop_q;
        unique case (state_q)
            IFU_REQ: begin
                // An issued request cannot be recalled, so its response is marked for discard.
                if (req_ready) begin
                    state_d = IFU_WAIT;
                end
                if (redirect) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            IFU_WAIT: begin
                if (resp_valid) begin
                    if (redirect) begin
                        pc_d         = target;
                        fetch_addr_d = target;
                        drop_d       = 1'b0;
                        state_d      = IFU_REQ;
                    end else if (drop_q) begin
                        fetch_addr_d = pc_q;
                        drop_d       = 1'b0;
                        state_d      = IFU_REQ;
                    end else begin
                        inst_d    = resp_inst;
                        inst_pc_d = fetch_addr_q;
                        state_d   = IFU_HOLD;
                    end
                end else if (redirect) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (redirect) begin
                    pc_d         = target;
                    fetch_addr_d = target;
                    state_d      = IFU_REQ;
                end else if (out_ready) begin
                    pc_d         = inst_pc_q + PC_STEP;
                    fetch_addr_d = inst_pc_q + PC_STEP;
                    state_d      = IFU_REQ;
                end
            end
            default: begin
                state_d = IFU_REQ;
            end
        endcase
    end

    // Handshake valids are masked by rst_n so nothing is offered while reset is held.
    always_comb begin
        req_valid = rst_n & (state_q == IFU_REQ);
        req_addr  = fetch_addr_q;
        out_valid = rst_n & (state_q == IFU_HOLD);
        out_inst  = inst_q;
        out_pc    = inst_pc_q;
        flush     = redirect;
    end

endmodule

// File: tb/tb_ifu_pc_gen.sv
// tb/tb_ifu_pc_gen.sv - table-driven bench for ifu_pc_gen with a latency-programmable IMEM model
module tb_ifu_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_fire = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = 32'd0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_inst = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rr;
        logic        orr;
        int          lat;
        logic        ef;
        logic        bt;
        logic [31:0] btgt;
        logic        jv;
        logic [31:0] jtgt;
        logic        stale;
        logic        erv;
        logic [31:0] eaddr;
        logic        eov;
        logic [31:0] epc;
        logic        efl;
    } vec_t;

    vec_t vecs[$];

    bit          pend = 1'b0;
    int          due = 0;
    int          cyc = 0;
    logic [31:0] pend_addr = 32'd0;

    ifu_pc_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_fire    (ex_fire),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_inst  (resp_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    function automatic vec_t mk(input logic rr, input logic orr, input int lat,
                                input logic ef, input logic bt, input logic [31:0] btgt,
                                input logic jv, input logic [31:0] jtgt, input logic stale,
                                input logic erv, input logic [31:0] eaddr,
                                input logic eov, input logic [31:0] epc, input logic efl);
        vec_t v;
        v.rr = rr; v.orr = orr; v.lat = lat; v.ef = ef; v.bt = bt; v.btgt = btgt;
        v.jv = jv; v.jtgt = jtgt; v.stale = stale; v.erv = erv; v.eaddr = eaddr;
        v.eov = eov; v.epc = epc; v.efl = efl;
        return v;
    endfunction

    task automatic chk(input string what, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", what, idx, got, exp);
        end
    endtask

    // IMEM: a request accepted in cycle k answers in cycle k+lat.
    task automatic imem_eval(input int lat, input logic stale);
        resp_valid = 1'b0;
        if (pend && due == cyc) begin
            resp_valid = 1'b1;
            resp_inst  = inst_of(pend_addr);
            pend       = 1'b0;
        end
        if (stale) begin
            resp_valid = 1'b1;
            resp_inst  = 32'hDEAD_BEEF;
        end
        if (req_valid && req_ready) begin
            pend      = 1'b1;
            due       = cyc + lat;
            pend_addr = req_addr;
        end
    endtask

    task automatic run_row(input vec_t v, input int idx);
        req_ready  = v.rr;
        out_ready  = v.orr;
        ex_fire    = v.ef;
        br_taken   = v.bt;
        br_target  = v.btgt;
        jmp_valid  = v.jv;
        jmp_target = v.jtgt;
        #1;
        imem_eval(v.lat, v.stale);
        #1;
        chk("req_valid", idx, {31'd0, req_valid}, {31'd0, v.erv});
        if (v.erv) chk("req_addr", idx, req_addr, v.eaddr);
        chk("out_valid", idx, {31'd0, out_valid}, {31'd0, v.eov});
        if (v.eov) begin
            chk("out_pc", idx, out_pc, v.epc);
            chk("out_inst", idx, out_inst, inst_of(v.epc));
        end
        chk("flush", idx, {31'd0, flush}, {31'd0, v.efl});
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // rr orr lat  ef bt btgt  jv jtgt  stale | erv eaddr  eov epc  fl
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0000, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0000, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0000, 0,32'h0,0));
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0000, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        vecs.push_back(mk(0,1,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         1,32'h8000_0000,0));
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0004, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,     1,32'h8000_0004,0));
        vecs.push_back(mk(0,1,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         1,32'h8000_0004,0));
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0008, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        vecs.push_back(mk(0,1,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         1,32'h8000_0008,0));
        // redirect while waiting on a slow response
        vecs.push_back(mk(1,0,2, 0,0,32'h0,0,32'h0,0, 1,32'h8000_000C, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 1,1,32'h8000_0100,0,32'h0,0, 0,32'h0, 0,32'h0,1));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0100, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        vecs.push_back(mk(0,1,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         1,32'h8000_0100,0));
        // jump beats branch, same cycle as the response
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0104, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 1,1,32'h8000_0400,1,32'h8000_0203,0, 0,32'h0, 0,32'h0,1));
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0200, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        // redirect in HOLD with out_ready high
        vecs.push_back(mk(0,1,1, 1,1,32'h8000_0040,0,32'h0,0, 0,32'h0, 1,32'h8000_0200,1));
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0040, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        vecs.push_back(mk(0,1,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         1,32'h8000_0040,0));
        // redirect in REQ, then again in WAIT while drop is pending
        vecs.push_back(mk(1,0,2, 1,0,32'h0,1,32'h8000_0080,0, 1,32'h8000_0044, 0,32'h0,1));
        vecs.push_back(mk(0,0,1, 1,1,32'h8000_00C0,0,32'h0,0, 0,32'h0, 0,32'h0,1));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_00C0, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,1,32'h8000_0500,1,32'h8000_0600,0, 0,32'h0, 0,32'h0,0));
        vecs.push_back(mk(0,1,1, 1,0,32'h8000_0500,0,32'h0,0, 0,32'h0, 1,32'h8000_00C0,0));
        // jump to the top word, then sequential wrap to zero
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_00C4, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        vecs.push_back(mk(0,0,1, 1,0,32'h0,1,32'hFFFF_FFFC,0, 0,32'h0, 1,32'h8000_00C4,1));
        vecs.push_back(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'hFFFF_FFFC, 0,32'h0,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0));
        vecs.push_back(mk(0,1,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         1,32'hFFFF_FFFC,0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h0000_0000, 0,32'h0,0));

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", -1, {31'd0, req_valid}, 32'd0);
        chk("rst_out_valid", -1, {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        cyc++;

        foreach (vecs[i]) run_row(vecs[i], i);

        // Asynchronous reset mid-WAIT with a response still owed by IMEM.
        run_row(mk(1,0,3, 0,0,32'h0,0,32'h0,0, 1,32'h0000_0000, 0,32'h0,0), 100);
        run_row(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0), 101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req_valid", 102, {31'd0, req_valid}, 32'd0);
        chk("async_out_valid", 102, {31'd0, out_valid}, 32'd0);
        pend = 1'b0;
        resp_valid = 1'b0;
        @(negedge clk);
        cyc++;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        run_row(mk(0,0,1, 0,0,32'h0,0,32'h0,1, 1,32'h8000_0000, 0,32'h0,0), 103);
        run_row(mk(1,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0000, 0,32'h0,0), 104);
        run_row(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         0,32'h0,0), 105);
        run_row(mk(0,1,1, 0,0,32'h0,0,32'h0,0, 0,32'h0,         1,32'h8000_0000,0), 106);
        run_row(mk(0,0,1, 0,0,32'h0,0,32'h0,0, 1,32'h8000_0004, 0,32'h0,0), 107);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
